// File: rtl/wshb_arb_pkg.sv
// rtl/wshb_arb_pkg.sv - shared types and constants for the two-master Wishbone round-robin arbiter
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_MIRE = 2'd2
    } arb_state_t;

    typedef enum logic {
        M_VGA  = 1'b0,
        M_MIRE = 1'b1
    } master_t;

    // Wishbone registered-feedback cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int CNT_W  = 16;
    localparam int ADR_W  = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

endpackage

// File: rtl/wshb_quantum_cnt.sv
// rtl/wshb_quantum_cnt.sv - saturating per-tenure termination counter with quantum expiry flag
module wshb_quantum_cnt
    import wshb_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_inc,
    input  logic [W-1:0] i_quantum,
    output logic         o_expired
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_q_eff;

    // A quantum of zero would never let the owner finish a transaction, so it behaves as one
    assign w_q_eff = (i_quantum == '0) ? ONE : i_quantum;

    // Count terminations in the current tenure, stopping at the quantum
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt < w_q_eff)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    // Expired means the termination currently on the bus is the last one this tenure may take
    assign o_expired = (r_cnt >= (w_q_eff - ONE));

endmodule

// File: rtl/wshb_rr_arbiter.sv
// rtl/wshb_rr_arbiter.sv - round-robin Wishbone arbiter sharing the SDRAM port between VGA and mire
module wshb_rr_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int VGA_QUANTUM  = 64,
    parameter int MIRE_QUANTUM = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    // master 0: VGA frame reader
    input  logic              i_vga_cyc,
    input  logic              i_vga_stb,
    input  logic              i_vga_we,
    input  logic [ADR_W-1:0]  i_vga_adr,
    input  logic [DATA_W-1:0] i_vga_dat_ms,
    input  logic [SEL_W-1:0]  i_vga_sel,
    input  logic [2:0]        i_vga_cti,
    input  logic [1:0]        i_vga_bte,
    output logic              o_vga_ack,
    output logic              o_vga_err,
    output logic              o_vga_rty,
    output logic [DATA_W-1:0] o_vga_dat_sm,
    // master 1: mire pattern writer
    input  logic              i_mire_cyc,
    input  logic              i_mire_stb,
    input  logic              i_mire_we,
    input  logic [ADR_W-1:0]  i_mire_adr,
    input  logic [DATA_W-1:0] i_mire_dat_ms,
    input  logic [SEL_W-1:0]  i_mire_sel,
    input  logic [2:0]        i_mire_cti,
    input  logic [1:0]        i_mire_bte,
    output logic              o_mire_ack,
    output logic              o_mire_err,
    output logic              o_mire_rty,
    output logic [DATA_W-1:0] o_mire_dat_sm,
    // shared bus toward SDRAM
    output logic              o_m_cyc,
    output logic              o_m_stb,
    output logic              o_m_we,
    output logic [ADR_W-1:0]  o_m_adr,
    output logic [DATA_W-1:0] o_m_dat_ms,
    output logic [SEL_W-1:0]  o_m_sel,
    output logic [2:0]        o_m_cti,
    output logic [1:0]        o_m_bte,
    input  logic              i_m_ack,
    input  logic              i_m_err,
    input  logic              i_m_rty,
    input  logic [DATA_W-1:0] i_m_dat_sm
);

    localparam logic [CNT_W-1:0] VGA_Q  = CNT_W'(VGA_QUANTUM);
    localparam logic [CNT_W-1:0] MIRE_Q = CNT_W'(MIRE_QUANTUM);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    master_t          r_last;
    master_t          w_next_last;
    logic             w_gnt_vga;
    logic             w_gnt_mire;
    logic             w_term;
    logic             w_clear;
    logic             w_expired;
    logic [CNT_W-1:0] w_quantum;

    assign w_gnt_vga  = (r_state == GNT_VGA);
    assign w_gnt_mire = (r_state == GNT_MIRE);

    // Forward the owner's request signals; the bus is fully quiet when nobody owns it
    always_comb begin
        o_m_cyc    = 1'b0;
        o_m_stb    = 1'b0;
        o_m_we     = 1'b0;
        o_m_adr    = '0;
        o_m_dat_ms = '0;
        o_m_sel    = '0;
        o_m_cti    = '0;
        o_m_bte    = '0;
        if (w_gnt_vga) begin
            o_m_cyc    = i_vga_cyc;
            o_m_stb    = i_vga_stb;
            o_m_we     = i_vga_we;
            o_m_adr    = i_vga_adr;
            o_m_dat_ms = i_vga_dat_ms;
            o_m_sel    = i_vga_sel;
            o_m_cti    = i_vga_cti;
            o_m_bte    = i_vga_bte;
        end else if (w_gnt_mire) begin
            o_m_cyc    = i_mire_cyc;
            o_m_stb    = i_mire_stb;
            o_m_we     = i_mire_we;
            o_m_adr    = i_mire_adr;
            o_m_dat_ms = i_mire_dat_ms;
            o_m_sel    = i_mire_sel;
            o_m_cti    = i_mire_cti;
            o_m_bte    = i_mire_bte;
        end
    end

    // Responses go only to the owner; read data is harmless to broadcast
    assign o_vga_ack     = w_gnt_vga  & i_m_ack;
    assign o_vga_err     = w_gnt_vga  & i_m_err;
    assign o_vga_rty     = w_gnt_vga  & i_m_rty;
    assign o_mire_ack    = w_gnt_mire & i_m_ack;
    assign o_mire_err    = w_gnt_mire & i_m_err;
    assign o_mire_rty    = w_gnt_mire & i_m_rty;
    assign o_vga_dat_sm  = i_m_dat_sm;
    assign o_mire_dat_sm = i_m_dat_sm;

    // Any slave response to an active strobe ends one transaction (or one burst beat)
    assign w_term    = o_m_stb & (i_m_ack | i_m_err | i_m_rty);
    assign w_quantum = w_gnt_mire ? MIRE_Q : VGA_Q;

    // One counter serves whichever master owns the bus; it restarts on every grant
    wshb_quantum_cnt #(
        .W (CNT_W)
    ) u_quantum_cnt (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_clear   (w_clear),
        .i_inc     (w_term),
        .i_quantum (w_quantum),
        .o_expired (w_expired)
    );

    // Arbitration state and round-robin history registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_last  <= M_MIRE;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
        end
    end

    // Grant selection from IDLE and release decisions while a master owns the bus
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                // The master that did not go last gets first pick
                if (r_last == M_MIRE) begin
                    if (i_vga_cyc) begin
                        w_next_state = GNT_VGA;
                        w_next_last  = M_VGA;
                        w_clear      = 1'b1;
                    end else if (i_mire_cyc) begin
                        w_next_state = GNT_MIRE;
                        w_next_last  = M_MIRE;
                        w_clear      = 1'b1;
                    end
                end else begin
                    if (i_mire_cyc) begin
                        w_next_state = GNT_MIRE;
                        w_next_last  = M_MIRE;
                        w_clear      = 1'b1;
                    end else if (i_vga_cyc) begin
                        w_next_state = GNT_VGA;
                        w_next_last  = M_VGA;
                        w_clear      = 1'b1;
                    end
                end
            end
            GNT_VGA: begin
                // Preempt only between transactions, never inside an incrementing burst
                if (!i_vga_cyc ||
                    (w_term && w_expired && (i_vga_cti != CTI_INCR) && i_mire_cyc)) begin
                    w_next_state = IDLE;
                end
            end
            GNT_MIRE: begin
                if (!i_mire_cyc ||
                    (w_term && w_expired && (i_mire_cti != CTI_INCR) && i_vga_cyc)) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
